// File: rtl/bubble_sort_ctrl.sv
// Load-sort-drain bubble sort controller, one compare-swap per cycle.
// Optional feature macro: BUBBLE_EARLY_EXIT_EN (stop after a swap-free pass).
module bubble_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [15:0]  cmp_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] LASTP = IW'(N - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

  state_e state_q, state_d;
  logic [IW-1:0] k_q, k_d, m_q, m_d;
  logic [IW-1:0] j_q, j_d, p_q, p_d;
  logic [W-1:0]  a_q [N];
  logic [W-1:0]  a_d [N];
  logic [15:0]   cnt_q, cnt_d, cmp_q, cmp_d;
  logic          swp_q, swp_d;

  logic [IW-1:0] jn;
  logic          swap, pass_end, last_pass;
  logic          pass_swap, exit_now;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    m_d       = m_q;
    j_d       = j_q;
    p_d       = p_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    swp_d     = swp_q;
    jn        = j_q + IW'(1);
    swap      = 1'b0;
    pass_end  = (j_q == (LASTP - p_q));
    last_pass = (p_q == LASTP);
    pass_swap = swp_q;
    exit_now  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          a_d[k_q] = in_data;
          if (k_q == LAST) begin
            k_d     = '0;
            j_d     = '0;
            p_d     = '0;
            cnt_d   = '0;
            swp_d   = 1'b0;
            state_d = SORT;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end
      SORT: begin
        swap = a_q[j_q] > a_q[jn];
        if (swap) begin
          a_d[j_q] = a_q[jn];
          a_d[jn]  = a_q[j_q];
        end
        cnt_d     = cnt_q + 16'd1;
        pass_swap = swp_q | swap;
        swp_d     = pass_swap;
`ifdef BUBBLE_EARLY_EXIT_EN
        exit_now  = last_pass | ~pass_swap;
`else
        exit_now  = last_pass;
`endif
        if (pass_end) begin
          swp_d = 1'b0;
          j_d   = '0;
          if (exit_now) begin
            cmp_d   = cnt_q + 16'd1;
            m_d     = '0;
            state_d = DRAIN;
          end else begin
            p_d = p_q + IW'(1);
          end
        end else begin
          j_d = jn;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (m_q == LAST) begin
            m_d     = '0;
            state_d = LOAD;
          end else begin
            m_d = m_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      k_q     <= '0;
      m_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      swp_q   <= 1'b0;
      for (int i = 0; i < N; i++) a_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      j_q     <= j_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      swp_q   <= swp_d;
      a_q     <= a_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == SORT);
  assign out_data  = (state_q == DRAIN) ? a_q[m_q] : '0;
  assign cmp_count = cmp_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench for bubble_sort_ctrl (N=4, W=8).
// Expected words come from a queue sort; compare counts from pass rules.
module tb_bubble_sort_ctrl;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BOUND = 400;

  typedef logic [W-1:0] job_t [N];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic [15:0]  cmp_count;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q [$];
  int           cmp_q [$];

  always #5 clk = ~clk;

  bubble_sort_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_cmp(input job_t v);
    int c;
`ifdef BUBBLE_EARLY_EXIT_EN
    logic [W-1:0] t [N];
    logic [W-1:0] tmp;
    bit sw;
    c = 0;
    t = v;
    for (int p = 0; p < N - 1; p++) begin
      sw = 0;
      for (int j = 0; j < N - 1 - p; j++) begin
        c++;
        if (t[j] > t[j+1]) begin
          tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp; sw = 1;
        end
      end
      if (!sw) break;
    end
`else
    c = N * (N - 1) / 2;
`endif
    return c;
  endfunction

  task automatic push_exp(input job_t v);
    logic [W-1:0] s [$];
    for (int i = 0; i < N; i++) s.push_back(v[i]);
    s.sort();
    foreach (s[i]) exp_q.push_back(s[i]);
    cmp_q.push_back(model_cmp(v));
  endtask

  task automatic load_job(input job_t v, input bit push, input bit gaps);
    int t;
    if (push) push_exp(v);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < BOUND) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("load_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_drain(input bit rnd);
    int t = 0;
    while (exp_q.size() != 0 && t < BOUND) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(2) != 0);
      t++;
    end
    out_ready = 1'b1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard pops plus handshake-protocol checks.
  int           widx, busy_cnt;
  bit           hold, prev_hs, prev_last, prev_busy;
  logic [W-1:0] hold_data;
  logic [W-1:0] e;
  int           ec;

  always @(negedge clk) begin
    if (!rst_n) begin
      widx = 0; busy_cnt = 0; hold = 0;
      prev_hs = 0; prev_last = 0; prev_busy = 0;
    end else begin
      if (prev_busy && !busy) chk("valid_after_sort", out_valid, 1);
      if (prev_hs && !prev_last) chk("drain_continuous", out_valid, 1);
      if (prev_last) chk("reload_ready", {out_valid, in_ready}, 2'b01);
      if (hold) chk("hold_data", {out_valid, out_data}, {1'b1, hold_data});
      if (busy) busy_cnt++;
      prev_busy = busy;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_data, 0);
          chk("unexpected_word_flag", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
        if (widx == 0 && cmp_q.size() != 0) begin
          ec = cmp_q.pop_front();
          chk("cmp_count", cmp_count, ec);
          chk("busy_cycles", busy_cnt, ec);
          busy_cnt = 0;
        end
        prev_last = (widx == N - 1);
        widx = (widx == N - 1) ? 0 : widx + 1;
        hold = 0;
        prev_hs = 1;
      end else begin
        hold = out_valid;
        hold_data = out_data;
        prev_hs = 0;
        prev_last = 0;
      end
    end
  end

  job_t v;
  int   t;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmp_count", cmp_count, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;

    v = '{8'd2, 8'd4, 8'd1, 8'd3};
    load_job(v, 1, 0);
    wait_drain(0);

    v = '{8'd1, 8'd2, 8'd3, 8'd4};
    load_job(v, 1, 0);
    wait_drain(0);

    v = '{8'd5, 8'd5, 8'd5, 8'd5};
    load_job(v, 1, 0);
    wait_drain(0);

    v = '{8'd9, 8'd7, 8'd3, 8'd0};
    out_ready = 1'b0;
    load_job(v, 1, 0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("drain_entry_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(0);

    v = '{8'd3, 8'd1, 8'd2, 8'd0};
    load_job(v, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midsort_busy", busy, 0);
    chk("midsort_in_ready", in_ready, 1);
    chk("midsort_out_valid", out_valid, 0);
    chk("midsort_cmp_count", cmp_count, 0);
    @(posedge clk); #1;
    v = '{8'd8, 8'd6, 8'd4, 8'd2};
    load_job(v, 1, 0);
    wait_drain(0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        v[i] = (r % 2) ? W'($urandom_range(3)) : W'($urandom);
      load_job(v, 1, 1);
      wait_drain(1);
    end

    chk("queue_empty", exp_q.size() + cmp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
